qmac_seq: RTL
=============

# qmac_seq

Sequencing multiply-accumulate front end for the sequential sign-magnitude fixed-point multiplier `qmults`.
- Accepts a stream of operand pairs over a valid/ready handshake and issues each pair to the multiplier with a one-cycle start pulse.
- Waits for the multiplier's completion, then adds each product into a saturating sign-magnitude accumulator.
- Reports the dot-product result after a programmed number of terms.
- Sits directly upstream of `qmults`, driving its `i_start`, `i_multiplicand` and `i_multiplier`, and consumes its `o_result_out`, `o_complete` and `o_overflow`.

## Interface
Parameters:
- `N`, 16: word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- `Q`, 8: fractional bits of the magnitude. Must match the attached `qmults`.
- `LEN_W`, 8: width of the term count.
- `TMO`, 64: number of cycles to wait for multiplier completion before aborting.

Ports:
- `i_clk` in 1: clock. One clock domain, rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_go` in 1: start a dot product. Sampled only in IDLE.
- `i_len` in LEN_W: number of terms. Sampled together with `i_go`.
- `i_a`, `i_b` in N: operand pair, sign-magnitude.
- `i_valid` in 1: the operand pair is valid.
- `o_ready` out 1: the block accepts an operand pair.
- `o_mul_multiplicand`, `o_mul_multiplier` out N: operands to `qmults`.
- `o_mul_start` out 1: one-cycle start pulse to `qmults`.
- `i_mul_result` in N: product from `qmults`.
- `i_mul_complete` in 1: completion level from `qmults`. It is held high between operations.
- `i_mul_overflow` in 1: product overflow from `qmults`.
- `o_acc` out N: accumulated result, sign-magnitude.
- `o_done` out 1: one-cycle pulse; `o_acc`, `o_overflow` and `o_error` are valid.
- `o_overflow` out 1: sticky for the current dot product.
- `o_error` out 1: multiplier timeout occurred.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
States and transitions:
- IDLE: on `i_go`, clear the accumulator, count, `o_overflow` and `o_error`, and latch `i_len`. If `i_len`==0, go to DONE; otherwise go to WAIT_OP.
- WAIT_OP: `o_ready`=1. When `i_valid` & `o_ready` are sampled high, register `i_a`/`i_b` onto `o_mul_multiplicand`/`o_mul_multiplier` and go to ISSUE.
- ISSUE: `o_mul_start`=1 for exactly this cycle. Go to ARM.
- ARM: wait until `i_mul_complete`=0, which discards the stale high level left by the previous operation. Then go to WAIT_MUL.
- WAIT_MUL: on the first cycle with `i_mul_complete`=1, register `i_mul_result` and OR `i_mul_overflow` into `o_overflow`. Go to ACCUM.
- ACCUM: add the product, increment the count. If count==len, go to DONE; otherwise go to WAIT_OP.
- DONE: `o_done`=1 for one cycle. Go to IDLE.

Timeout:
- The cycle counter runs in ARM and WAIT_MUL combined and resets when ISSUE is entered.
- Reaching TMO sets `o_error`=1 and jumps to DONE. `o_acc` keeps its partial sum.

Arithmetic:
- Convert both operands to N+1-bit two's complement and add.
- If the sum exceeds +(2^(N-1)-1) or falls below -(2^(N-1)-1), clamp to that bound and set `o_overflow`.
- Convert back to sign-magnitude. A zero magnitude always gets sign 0; an input of -0 is treated as +0.

Other behaviour:
- Operand registers stay stable from ISSUE until the next handshake.
- `o_acc` holds its value after DONE until the next `i_go` is accepted. It is not zeroed until then.
- `i_go` while `o_busy`=1 is ignored.
- `i_valid` outside WAIT_OP is ignored; the operand pair is not consumed.

## Timing
- All outputs are registered.
- Reset values: `o_ready`=0, `o_mul_start`=0, `o_mul_multiplicand`=0, `o_mul_multiplier`=0, `o_acc`=0, `o_done`=0, `o_overflow`=0, `o_error`=0, `o_busy`=0. State is IDLE.
- `i_go` sampled at edge k: `o_busy`=1 and `o_ready`=1 from k+1.
- Handshake at edge h: `o_ready`=0 and `o_mul_start`=1 during cycle h+1.
- Complete sampled at edge c: accumulate at c+1. `o_done` is high in cycle c+2 for the last term; otherwise `o_ready`=1 in cycle c+2.
- `i_len`=0: `o_done` is high in cycle k+2 with `o_acc`=0.
- Reset mid-operation: `i_rst_n`=0 sampled at an edge forces all outputs to their reset values at that edge.
  - `o_mul_start` is never left asserted.
  - Any multiplier completion arriving later is ignored, because the state is IDLE.
- Simultaneous `i_go` and `i_valid` in IDLE: the operand pair is not consumed in that cycle.

## Test plan
The bench uses the real `qmults` with N=16, Q=8, where 1.0 = 0x0100.
- Basic dot product: `i_len`=2, pairs (0x0100,0x0200) then (0x8300,0x0100) -> one `o_done`, `o_acc`=0x8100, `o_overflow`=0, `o_error`=0. Exactly two `o_mul_start` pulses, each one cycle wide.
- Saturation: `i_len`=2, pairs (0x5000,0x0100) twice -> `o_acc`=0x7FFF, `o_overflow`=1.
- Cancellation to zero: `i_len`=2, pairs (0x0300,0x0100) then (0x8300,0x0100) -> `o_acc`=0x0000, not 0x8000.
- Zero length: `i_go` with `i_len`=0 -> `o_done` in cycle k+2, `o_acc`=0, `o_mul_start` never asserted. A second `i_go` during `o_busy` is ignored.
- Timeout: replace the multiplier with a stub that holds `i_mul_complete`=0 -> after 64 cycles in ARM/WAIT_MUL, `o_done`=1 with `o_error`=1.
- Reset mid-operation: assert `i_rst_n`=0 for one edge during WAIT_MUL -> all outputs are 0 at that edge. The subsequent `o_complete` produces no `o_done`. A fresh 1-term run with (0x0200,0x0200) gives `o_acc`=0x0400.

Source files
------------

// File: rtl/qmac_seq.sv
// Dot-product sequencer in front of the sequential sign-magnitude multiplier qmults.
// Operand pairs come in over valid/ready and are multiplied one at a time into a saturating accumulator.
module qmac_seq #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int LEN_W = 8,
  parameter int TMO   = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_go,
  input  logic [LEN_W-1:0] i_len,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [N-1:0]     o_mul_multiplicand,
  output logic [N-1:0]     o_mul_multiplier,
  output logic             o_mul_start,
  input  logic [N-1:0]     i_mul_result,
  input  logic             i_mul_complete,
  input  logic             i_mul_overflow,
  output logic [N-1:0]     o_acc,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_error,
  output logic             o_busy
);

  if (Q > N - 2) begin : g_q_range
    $error("qmac_seq: Q must leave at least one integer magnitude bit");
  end

  localparam int TW = $clog2(TMO + 1);
  localparam logic signed [N:0] MAXV = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] MINV = -MAXV;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_OP, S_ISSUE, S_ARM, S_WAIT_MUL, S_ACCUM, S_DONE
  } state_e;

  state_e           state_q;
  logic [TW-1:0]    tmo_q;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_d;
  logic [N-1:0]     prod_q, acc_d;
  logic signed [N:0] sum, sat_sum;
  logic [N-2:0]     mag;
  logic             sat;

  // -0 maps to 0 here, so it never survives into the sum
  function automatic logic signed [N:0] sm2tc(input logic [N-1:0] v);
    logic signed [N:0] m;
    m = $signed({2'b00, v[N-2:0]});
    return v[N-1] ? -m : m;
  endfunction

  always_comb begin
    sum     = sm2tc(o_acc) + sm2tc(prod_q);
    sat     = 1'b0;
    sat_sum = sum;
    if (sum > MAXV) begin
      sat_sum = MAXV;
      sat     = 1'b1;
    end else if (sum < MINV) begin
      sat_sum = MINV;
      sat     = 1'b1;
    end
    mag   = (sat_sum < 0) ? (N-1)'(-sat_sum) : (N-1)'(sat_sum);
    acc_d = {sat_sum < 0, mag};
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q            <= S_IDLE;
      tmo_q              <= '0;
      len_q              <= '0;
      cnt_q              <= '0;
      prod_q             <= '0;
      o_ready            <= 1'b0;
      o_mul_start        <= 1'b0;
      o_mul_multiplicand <= '0;
      o_mul_multiplier   <= '0;
      o_acc              <= '0;
      o_done             <= 1'b0;
      o_overflow         <= 1'b0;
      o_error            <= 1'b0;
      o_busy             <= 1'b0;
    end else begin
      o_mul_start <= 1'b0;
      o_done      <= 1'b0;
      case (state_q)
        S_IDLE: if (i_go) begin
          o_acc      <= '0;
          cnt_q      <= '0;
          o_overflow <= 1'b0;
          o_error    <= 1'b0;
          len_q      <= i_len;
          o_busy     <= 1'b1;
          if (i_len == '0) state_q <= S_DONE;
          else begin
            state_q <= S_WAIT_OP;
            o_ready <= 1'b1;
          end
        end
        S_WAIT_OP: if (i_valid && o_ready) begin
          o_mul_multiplicand <= i_a;
          o_mul_multiplier   <= i_b;
          o_ready            <= 1'b0;
          o_mul_start        <= 1'b1;
          tmo_q              <= '0;
          state_q            <= S_ISSUE;
        end
        S_ISSUE: state_q <= S_ARM;
        S_ARM: begin
          if (tmo_q == TW'(TMO - 1)) begin
            o_error <= 1'b1;
            o_done  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!i_mul_complete) state_q <= S_WAIT_MUL;
          end
        end
        S_WAIT_MUL: begin
          if (i_mul_complete) begin
            prod_q     <= i_mul_result;
            o_overflow <= o_overflow | i_mul_overflow;
            state_q    <= S_ACCUM;
          end else if (tmo_q == TW'(TMO - 1)) begin
            o_error <= 1'b1;
            o_done  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_ACCUM: begin
          o_acc      <= acc_d;
          o_overflow <= o_overflow | sat;
          cnt_q      <= cnt_d;
          if (cnt_d == len_q) begin
            o_done  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            o_ready <= 1'b1;
            state_q <= S_WAIT_OP;
          end
        end
        // Entered with o_done already set from ACCUM/timeout; the zero-length path
        // arrives with it clear and raises it here, one cycle later.
        S_DONE: begin
          if (o_done) begin
            o_busy  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            o_done <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
